// File: rtl/uart_tx_gen.sv
// UART transmitter with a one-entry holding buffer for back-to-back frames.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits.
module uart_tx_gen #(
  parameter int CLKS_PER_BIT = 3603,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  input  logic                 i_Parity_Odd,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  localparam logic [11:0] CNT_MAX   = 12'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t               state_q;
  state_t               state_d;
  logic [11:0]          cnt_q;
  logic [11:0]          cnt_d;
  logic [3:0]           idx_q;
  logic [3:0]           idx_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] hold_word_q;
  logic                 hold_full_q;
  logic                 serial_q;
  logic                 serial_d;

  logic                 bit_end;
  logic                 frame_end;
  logic                 xfer;
  logic                 load_in;
  logic                 load_hold;
  logic                 load;
  logic                 buf_wr;
  logic [DATA_BITS-1:0] load_word;

`ifdef UART_TX_PARITY_EN
  logic hold_par_q;
  logic par_q;
  logic par_d;
  logic load_par;
`else
  logic unused_parity;
  assign unused_parity = i_Parity_Odd;
`endif

  assign bit_end   = (cnt_q == CNT_MAX);
  assign frame_end = (state_q == STOP) && bit_end
                  && (idx_q == LAST_STOP);
  assign xfer      = i_Tx_DV && !hold_full_q;
  assign load_in   = xfer
                  && ((state_q == IDLE) || frame_end);
  assign load_hold = frame_end && hold_full_q;
  assign load      = load_in || load_hold;
  assign buf_wr    = xfer && !load_in;
  assign load_word = hold_full_q ? hold_word_q : i_Tx_Byte;

`ifdef UART_TX_PARITY_EN
  assign load_par  = hold_full_q ? hold_par_q : i_Parity_Odd;
`endif

  // State register
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stray encodings fall back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (xfer) state_d = START;
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end && idx_q == LAST_DATA)
          state_d = AFTER_DATA;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (frame_end)
          state_d = load ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timer, bit index and frame shift register
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (load) begin
      cnt_d   = '0;
      idx_d   = '0;
      shift_d = load_word;
`ifdef UART_TX_PARITY_EN
      par_d   = (^load_word) ^ load_par;
`endif
    end else if (state_q == IDLE) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (bit_end) begin
      cnt_d = '0;
      idx_d = (state_d == state_q)
            ? idx_q + 4'd1 : 4'd0;
      if (state_q == DATA)
        shift_d = shift_q >> 1;
    end else begin
      cnt_d = cnt_q + 12'd1;
    end
  end

  // Datapath registers; the line idles high
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Holding buffer: filled mid-frame, drained at frame end
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      hold_full_q <= 1'b0;
      hold_word_q <= '0;
`ifdef UART_TX_PARITY_EN
      hold_par_q  <= 1'b0;
`endif
    end else if (load_hold) begin
      hold_full_q <= 1'b0;
    end else if (buf_wr) begin
      hold_full_q <= 1'b1;
      hold_word_q <= i_Tx_Byte;
`ifdef UART_TX_PARITY_EN
      hold_par_q  <= i_Parity_Odd;
`endif
    end
  end

  // Line level for the coming cycle, from the next state
  always_comb begin
    serial_d = 1'b1;
    unique case (1'b1)
      (state_d == START): serial_d = 1'b0;
      (state_d == DATA):  serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      (state_d == PARITY): serial_d = par_d;
`endif
      default: serial_d = 1'b1;
    endcase
  end

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Ready  = !hold_full_q;
  assign o_Tx_Active = (state_q != IDLE);
  assign o_Tx_Done   = frame_end;

endmodule

// File: tb/tb_uart_tx_gen.sv
// Directed bench for uart_tx_gen: 8N1 and 5-bit/2-stop instances.
// Parity checks run when UART_TX_PARITY_EN is defined.
module tb_uart_tx_gen;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB  = 1 + 8 + P + 1;
  localparam int L   = NB * CPB;
  localparam int NB5 = 1 + 5 + P + 2;
  localparam int L5  = NB5 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dv;
  logic [7:0] tx_byte;
  logic       par;
  logic       ready, active, serial, done;
  logic       dv5;
  logic [4:0] tx_byte5;
  logic       ready5, active5, serial5, done5;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;
  int n_done5 = 0;
  int d0;
  logic [15:0] fb;
  logic [7:0]  w3 [3];
  logic [7:0]  w2 [2];

  always #5 clk = ~clk;

  uart_tx_gen #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)
  ) dut (
    .i_Clock(clk), .i_Rst_n(rst_n),
    .i_Tx_DV(dv), .i_Tx_Byte(tx_byte),
    .i_Parity_Odd(par), .o_Tx_Ready(ready),
    .o_Tx_Active(active), .o_Tx_Serial(serial),
    .o_Tx_Done(done)
  );

  uart_tx_gen #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2)
  ) dut5 (
    .i_Clock(clk), .i_Rst_n(rst_n),
    .i_Tx_DV(dv5), .i_Tx_Byte(tx_byte5),
    .i_Parity_Odd(par), .o_Tx_Ready(ready5),
    .o_Tx_Active(active5), .o_Tx_Serial(serial5),
    .o_Tx_Done(done5)
  );

  always @(posedge clk) begin
    if (done)  n_done++;
    if (done5) n_done5++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] fbits(
    input logic [8:0] w, input logic po,
    input int db, input int sb);
    logic [15:0] f;
    logic        x;
    int          k;
    f    = '1;
    f[0] = 1'b0;
    x    = po;
    for (int i = 0; i < db; i++) begin
      f[1+i] = w[i];
      x      = x ^ w[i];
    end
    k = 1 + db;
    if (P == 1) f[k] = x;
    if (sb < 1) f = '0;
    return f;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_ser"}, serial, 1);
    chk({tag, "_act"}, active, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdy"}, ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; dv = 1'b0; tx_byte = '0; par = 1'b0;
    dv5 = 1'b0; tx_byte5 = '0;
    w3[0] = 8'h11; w3[1] = 8'h22; w3[2] = 8'h33;
    w2[0] = 8'h5A; w2[1] = 8'hC3;
    tick; tick;
    chk_idle("rst");
    chk("rst_ser5", serial5, 1);
    chk("rst_rdy5", ready5, 1);
    chk("rst_act5", active5, 0);
    rst_n = 1'b1;
    tick;
    chk_idle("idle0");

    // single frame 0xA5
    fb = fbits(9'h0A5, 1'b0, 8, 1);
    dv = 1'b1; tx_byte = 8'hA5;
    tick;
    dv = 1'b0; tx_byte = 8'h00;
    d0 = n_done;
    for (int c = 0; c < L; c++) begin
      chk("a5_ser", serial, fb[c/CPB]);
      chk("a5_done", done, c == L - 1);
      chk("a5_act", active, 1);
      chk("a5_rdy", ready, 1);
      tick;
    end
    chk_idle("a5_end");
    chk("a5_ndone", n_done - d0, 1);

    // DV held through three words
    dv = 1'b1; tx_byte = 8'h11;
    tick;
    d0 = n_done;
    for (int c = 0; c < 3 * L; c++) begin
      fb = fbits({1'b0, w3[c/L]}, 1'b0, 8, 1);
      chk("b2b_ser", serial, fb[(c%L)/CPB]);
      chk("b2b_done", done, (c % L) == L - 1);
      chk("b2b_act", active, 1);
      chk("b2b_rdy", ready,
          (c == 0) || (c == L) || (c >= 2 * L));
      if (c == 0) tx_byte = 8'h22;
      if (c == L) tx_byte = 8'h33;
      if (c == L + 1) dv = 1'b0;
      tick;
    end
    chk_idle("b2b_end");
    chk("b2b_ndone", n_done - d0, 3);

    // DV on the final stop-bit cycle, buffer empty
    dv = 1'b1; tx_byte = 8'h5A;
    tick;
    dv = 1'b0;
    d0 = n_done;
    for (int c = 0; c < 2 * L; c++) begin
      fb = fbits({1'b0, w2[c/L]}, 1'b0, 8, 1);
      chk("last_ser", serial, fb[(c%L)/CPB]);
      chk("last_done", done, (c % L) == L - 1);
      chk("last_act", active, 1);
      chk("last_rdy", ready, 1);
      if (c == L - 1) begin
        dv = 1'b1; tx_byte = 8'hC3;
      end
      if (c == L) dv = 1'b0;
      tick;
    end
    chk_idle("last_end");
    chk("last_ndone", n_done - d0, 2);

    // reset during data bit 3 with a word buffered
    d0 = n_done;
    dv = 1'b1; tx_byte = 8'h3C;
    tick;
    tx_byte = 8'h99;
    tick;
    dv = 1'b0;
    chk("rst_buf_full", ready, 0);
    for (int c = 1; c < 17; c++) tick;
    chk("rst_d3_ser", serial, 1);
    chk("rst_d3_act", active, 1);
    rst_n = 1'b0; dv = 1'b1; tx_byte = 8'hFF;
    tick;
    chk_idle("rst_mid");
    tick;
    rst_n = 1'b1; dv = 1'b0;
    for (int c = 0; c < 2 * L; c++) begin
      chk("rst_after_ser", serial, 1);
      chk("rst_after_act", active, 0);
      tick;
    end
    chk("rst_ndone", n_done - d0, 0);

    // 5 data bits, 2 stop bits
    fb = fbits(9'h01F, 1'b0, 5, 2);
    dv5 = 1'b1; tx_byte5 = 5'h1F;
    tick;
    dv5 = 1'b0;
    d0 = n_done5;
    for (int c = 0; c < L5; c++) begin
      chk("d5_ser", serial5, fb[c/CPB]);
      chk("d5_done", done5, c == L5 - 1);
      chk("d5_act", active5, 1);
      tick;
    end
    chk("d5_end_act", active5, 0);
    chk("d5_end_ser", serial5, 1);
    chk("d5_ndone", n_done5 - d0, 1);

`ifdef UART_TX_PARITY_EN
    for (int po = 0; po < 2; po++) begin
      fb = fbits(9'h007, po[0], 8, 1);
      dv = 1'b1; tx_byte = 8'h07; par = po[0];
      tick;
      dv = 1'b0; par = ~po[0];
      for (int c = 0; c < L; c++) begin
        chk("par_ser", serial, fb[c/CPB]);
        chk("par_done", done, c == L - 1);
        if (c == 9 * CPB)
          chk("par_bit", serial, (po == 0) ? 1 : 0);
        tick;
      end
      chk_idle("par_end");
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_gen.md
UART_TX_GEN -- requirements
Module: uart_tx_gen

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 3603, meaning clock cycles per UART bit; legal range is 2..4095.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range is 5..9.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values are 1 and 2.
REQ-004 The block SHALL have port i_Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port i_Rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port i_Tx_DV, input, 1 bit: byte valid; a transfer occurs when i_Tx_DV=1 and o_Tx_Ready=1 at a rising edge.
REQ-007 The block SHALL have port i_Tx_Byte, input, DATA_BITS bits: data word, sampled on the transfer edge.
REQ-008 The block SHALL have port i_Parity_Odd, input, 1 bit: parity sense (0 = even, 1 = odd), sampled on the transfer edge.
REQ-009 The block SHALL have port o_Tx_Ready, output, 1 bit: the one-entry holding buffer is empty.
REQ-010 The block SHALL have port o_Tx_Active, output, 1 bit: a frame is on the line (start bit through last stop bit).
REQ-011 The block SHALL have port o_Tx_Serial, output, 1 bit: registered serial line, idle high.
REQ-012 The block SHALL have port o_Tx_Done, output, 1 bit: one-cycle pulse at the end of each frame.

Function
REQ-013 The state machine SHALL have the states IDLE, START, DATA, PARITY, and STOP, and SHALL return to IDLE from any unused encoding.
REQ-014 The block SHALL contain a one-entry holding buffer (word plus parity sense) and a separate shift register for the frame in progress.
REQ-015 o_Tx_Ready SHALL be 1 exactly when the holding buffer is empty, including while a frame is in progress.
REQ-016 On a transfer in IDLE, the word SHALL load directly into the shift register, the state SHALL go to START, and o_Tx_Serial SHALL be 0 from that same edge.
REQ-017 On a transfer outside IDLE, the word SHALL go into the holding buffer, and o_Tx_Ready SHALL drop on the next cycle.
REQ-018 Every bit on the line SHALL be held for exactly CLKS_PER_BIT cycles, timed by a 12-bit counter that counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
REQ-019 The frame order SHALL be: start bit (0), then data bits LSB first, then the parity bit (only when compiled in), then STOP_BITS stop bits (1).
REQ-020 The frame length SHALL be (1 + DATA_BITS + P + STOP_BITS) x CLKS_PER_BIT cycles, where P is 1 when parity is compiled in and 0 otherwise.
REQ-021 On the last cycle of the final stop bit, o_Tx_Done SHALL be 1 for exactly one cycle.
REQ-022 On that same cycle, if the holding buffer is full, the buffered word SHALL move to the shift register, the state SHALL go to START with no idle gap, and o_Tx_Ready SHALL go to 1 on the next cycle.
REQ-023 On that same cycle, if the holding buffer is empty and i_Tx_DV=1, the word SHALL go straight to the shift register and start back-to-back.
REQ-024 On that same cycle, if the holding buffer is empty and i_Tx_DV=0, the state SHALL go to IDLE with o_Tx_Serial=1 and o_Tx_Active=0.
REQ-025 o_Tx_Active SHALL be 1 from the start-bit edge through the last stop-bit cycle, and SHALL stay 1 continuously across back-to-back frames.
REQ-026 i_Tx_DV asserted while o_Tx_Ready=0 SHALL be ignored, leaving the holding buffer unchanged.
REQ-027 i_Tx_Byte and i_Parity_Odd SHALL be don't-care on every cycle except a transfer edge.

Reset
REQ-028 When i_Rst_n=0 at a rising edge, the state SHALL go to IDLE and the block SHALL set o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0, counters to 0, and the holding buffer to empty.
REQ-029 Reset SHALL take priority over every other event.
REQ-030 Reset in the middle of a frame SHALL abort that frame immediately, returning the line high, and SHALL discard any buffered word.
REQ-031 No transfer SHALL occur on any edge where i_Rst_n=0.

Configuration
REQ-032 With macro UART_TX_PARITY_EN defined, the PARITY state SHALL be compiled in and the parity bit SHALL equal the XOR of the data bits XOR i_Parity_Odd.
REQ-033 With UART_TX_PARITY_EN undefined, the PARITY state SHALL be absent, i_Parity_Odd SHALL remain a port but be ignored, and the transition SHALL go from the last data bit straight to STOP.

Verification
REQ-034 Scenario: CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, no parity; send 0xA5 once -> line reads 0,1,0,1,0,0,1,0,1,1, each level 4 cycles long, and o_Tx_Done pulses once at cycle 39 after the transfer.
REQ-035 Scenario: UART_TX_PARITY_EN defined; send 0x07 with i_Parity_Odd=0 -> parity bit is 1; send 0x07 with i_Parity_Odd=1 -> parity bit is 0; the frame is 44 cycles long.
REQ-036 Scenario: DV held high for three words 0x11, 0x22, 0x33 -> the first loads directly and the second buffers; o_Tx_Ready stays low until the 0x22 frame starts; the frames are back-to-back with no idle cycles; o_Tx_Active stays high throughout; there are 3 Done pulses.
REQ-037 Scenario: DATA_BITS=5, STOP_BITS=2, send 0x1F -> line reads 0,1,1,1,1,1,1,1 (8 bit times).
REQ-038 Scenario: assert i_Rst_n=0 during data bit 3 with a word in the buffer -> on the next cycle o_Tx_Serial=1, o_Tx_Ready=1, and o_Tx_Active=0; no Done pulse occurs; the buffered word is never sent.
REQ-039 Scenario: DV arrives on the exact final stop-bit cycle with the buffer empty -> the next cycle is a start bit and o_Tx_Done pulses once.
